// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU data memory
//   F3_B/F3_H/F3_W : funct3 of lb/sb, lh/sh, lw/sw
//   F3_BU/F3_HU    : funct3 of lbu, lhu (loads only)
//   state_t        : request FSM states IDLE, WAIT, RESP
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: request/response bus between a load/store unit and lsu_dmem
//   req_valid/req_ready : request handshake
//   req_we, req_funct3  : store select and RISC-V load/store funct3
//   req_addr, req_wdata : byte address and store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata, rsp_err  : extended load data and fault flag
interface lsu_dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane select, byte enables, load extension and access checks
//   we, funct3 : access type
//   lane       : addr[1:0]
//   wdata      : store data, replicated into every lane as wword
//   rword      : memory word being read, rdata is the extended lane
//   be         : byte enables of the addressed bytes
//   err        : unsupported funct3 or misaligned access
module lsu_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        err
);
   logic [1:0]  size;
   logic [15:0] sh;
   logic        sx;
   assign size  = funct3[1:0];
   assign sx    = !funct3[2];
   assign sh    = 16'(rword >> {lane, 3'b000});
   assign err   = (we ? !(funct3 inside {F3_B, F3_H, F3_W})
                      : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
                | (size == 2'd1 && lane[0]) | (size == 2'd2 && lane != 2'd0);
   assign be    = size == 2'd0 ? 4'b0001 << lane : size == 2'd1 ? 4'b0011 << lane : 4'b1111;
   assign wword = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
   assign rdata = size == 2'd0 ? {{24{sx & sh[7]}}, sh[7:0]}
                : size == 2'd1 ? {{16{sx & sh[15]}}, sh[15:0]} : rword;
endmodule

// File: rtl/lsu_dmem.sv
// lsu_dmem: single-outstanding data memory with fixed response latency
//   clk   : sole clock
//   reset : synchronous active-low reset (memory contents are kept)
//   bus   : lsu_dmem_if slave (request handshake, response pulse)
//   stat_loads/stat_stores/stat_errs : access counters, only with LSU_DMEM_STATS_EN
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
`ifdef LSU_DMEM_STATS_EN
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_errs,
`endif
   lsu_dmem_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem [DEPTH];
   logic          idle;
   logic          accept;
   logic          go_resp;
   logic          c_we;
   logic [2:0]    c_f3;
   logic [31:0]   c_addr;
   logic [31:0]   c_wdata;
   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   wword;
   logic [31:0]   rdata;
   logic          a_err;
   logic          err;
   logic          rsp_valid;
   logic          rsp_err;
   logic [31:0]   rsp_rdata;
   assign idle    = state == IDLE;
   assign accept  = idle && bus.req_valid;
   assign go_resp = (accept && LATENCY == 0) || (state == WAIT && cnt == 4'd0);
   // With LATENCY=0 the request completes on its accept edge, so in IDLE the
   // live inputs stand in for the not-yet-loaded capture registers.
   assign c_we    = idle ? bus.req_we : we_q;
   assign c_f3    = idle ? bus.req_funct3 : f3_q;
   assign c_addr  = idle ? bus.req_addr : addr_q;
   assign c_wdata = idle ? bus.req_wdata : wdata_q;
   assign idx     = c_addr[AW+1:2];
   lsu_align u_align (
      .we     (c_we),
      .funct3 (c_f3),
      .lane   (c_addr[1:0]),
      .wdata  (c_wdata),
      .rword  (mem[idx]),
      .be     (be),
      .wword  (wword),
      .rdata  (rdata),
      .err    (a_err)
   );
   assign err = a_err || c_addr[31:2] >= 30'(DEPTH);
   // Store commit and load sampling share the edge that enters RESP.
   always_ff @(posedge clk)
      if (reset && go_resp && c_we && !err)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= go_resp;
         rsp_err   <= go_resp && err;
         rsp_rdata <= go_resp && !err && !c_we ? rdata : '0;
         case (state)
            IDLE: if (accept) begin
               we_q    <= bus.req_we;
               f3_q    <= bus.req_funct3;
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               state   <= LATENCY == 0 ? RESP : WAIT;
               cnt     <= LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
            end
            WAIT: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
            default: state <= IDLE;
         endcase
      end
   end
`ifdef LSU_DMEM_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (state == RESP) begin
         if (rsp_err) stat_errs <= stat_errs + 32'd1;
         else if (we_q) stat_stores <= stat_stores + 32'd1;
         else stat_loads <= stat_loads + 32'd1;
      end
   end
`endif
   assign bus.req_ready = idle;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_err   = rsp_err;
endmodule

// File: doc/lsu_dmem.md
LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data memory depth in 32-bit words (power of two, 4..65536).
REQ-002 SHALL have parameter LATENCY, default 1, meaning wait cycles between accept and response (0..15).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports req_valid in 1 request present; req_ready out 1 request accepted this cycle.
REQ-006 SHALL have ports req_we in 1 store when 1; req_funct3 in 3 RISC-V load/store funct3; req_addr in 32 byte address; req_wdata in 32 store data.
REQ-007 SHALL have ports rsp_valid out 1 one-cycle response pulse; rsp_rdata out 32 extended load data; rsp_err out 1 access faulted.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-009 SHALL accept a request when req_valid & req_ready and capture we/funct3/addr/wdata into registers that stay unchanged until the response.
REQ-010 SHALL on accept go IDLE->WAIT with counter loaded to LATENCY-1, or IDLE->RESP when LATENCY = 0.
REQ-011 SHALL decrement the counter in WAIT and go WAIT->RESP when it reaches 0; RESP->IDLE always after one cycle.
REQ-012 SHALL give latency accept-to-rsp_valid = LATENCY+1 cycles and at most one request per LATENCY+2 cycles.
REQ-013 SHALL support loads lb 000, lh 001, lw 010, lbu 100, lhu 101; lb/lh sign-extend and lbu/lhu zero-extend the selected lane.
REQ-014 SHALL support stores sb 000, sh 001, sw 010, writing only addressed bytes via byte enables from req_addr[1:0]; other bytes keep old value.
REQ-015 SHALL commit a store to memory on the clock edge that enters RESP, never earlier.
REQ-016 SHALL sample load data in the cycle before RESP, so a load sees all stores whose response has already occurred.
REQ-017 SHALL flag error for halfword access with addr[0] = 1, word access with addr[1:0] != 0, unsupported funct3 (011, 110, 111, or 1xx with req_we = 1), or addr[31:2] >= DEPTH.
REQ-018 SHALL on error suppress the memory write, drive rsp_rdata = 0 and rsp_err = 1 with rsp_valid.
REQ-019 SHALL hold rsp_rdata and rsp_err at 0 whenever rsp_valid = 0; store responses return rsp_rdata = 0.
REQ-020 SHALL ignore req_valid and request inputs in WAIT and RESP (no queuing).

Reset
REQ-021 SHALL, when reset = 0 at a clock edge, enter IDLE, clear counter, rsp_valid, rsp_rdata and rsp_err; req_ready = 1 in the first cycle after reset is released.
REQ-022 SHALL abandon an in-flight request on reset with no memory write and no response.
REQ-023 SHALL NOT reset memory contents (testbench preloads with $readmemh).

Configuration
REQ-024 SHALL, with LSU_DMEM_STATS_EN defined, add outputs stat_loads, stat_stores, stat_errs (32 bits each), incremented on each RESP cycle by type (faulted accesses count only in stat_errs), cleared by reset, wrapping 0xFFFFFFFF->0.
REQ-025 SHALL, without LSU_DMEM_STATS_EN, have no such ports or counters; all other behaviour identical.

Structure
REQ-026 SHALL take funct3 load/store encodings and the FSM state enum from shared package lsu_pkg.
REQ-027 SHALL put lane select, byte-enable generation, extension and misalignment checks in combinational sub-module lsu_align.
REQ-028 SHALL hold memory as a 32-bit word array of DEPTH entries indexed by addr[31:2].

Verification
REQ-029 LATENCY=1: sw 0xDEADBEEF to 0x40, then lw 0x40 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-030 sb 0x80 to 0x41 over 0x00000000, then lb 0x41 -> 0xFFFFFF80; lbu 0x41 -> 0x00000080; lw 0x40 -> 0x00008000.
REQ-031 lh 0x43 and sw 0x42 -> rsp_err 1, rdata 0, word at 0x40 unchanged; lw 0x400 with DEPTH=256 -> rsp_err 1.
REQ-032 LATENCY=0: req_valid held high for back-to-back lw -> req_ready toggles 1,0, one response every 2 cycles.
REQ-033 Reset = 0 during WAIT of sw 0x12345678 to 0x10 (LATENCY=3) -> no rsp_valid, word at 0x10 unchanged, req_ready 1 after release.
REQ-034 LSU_DMEM_STATS_EN: 3 loads, 2 stores, 1 misaligned lw -> stat_loads 3, stat_stores 2, stat_errs 1.
